lap_stopwatch: RTL

LAP_STOPWATCH -- requirements
Module: lap_stopwatch

---
 rtl/stopwatch_pkg.sv | 28 ++
 rtl/bcd_digit.sv | 32 +++
 rtl/lap_stopwatch.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the lap stopwatch: segment table, digit moduli, run states.
package stopwatch_pkg;

    localparam int unsigned MAX_DIGITS = 8;

    typedef enum logic {
        StStopped = 1'b0,
        StRunning = 1'b1
    } run_state_e;

    // Active-low {g,f,e,d,c,b,a} codes for hex digits 0..F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic logic [6:0] seg_code(input logic [3:0] v);
        return SEG_TABLE[v];
    endfunction

    // Tens-of-seconds digit rolls over at 6, every other digit at 10.
    function automatic int unsigned digit_modulus(input int unsigned idx);
        return (idx == 2) ? 32'd6 : 32'd10;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal counter digit with synchronous clear and carry-in increment.
module bcd_digit #(
    parameter int unsigned MODULUS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] value,
    output logic       at_max
);

    logic [3:0] r_value;
    logic       w_at_max;

    assign w_at_max = (r_value == 4'(MODULUS - 1));

    // Digit register: clear wins, otherwise count and wrap at the modulus.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_value <= '0;
        end else if (clr) begin
            r_value <= '0;
        end else if (inc) begin
            r_value <= w_at_max ? 4'd0 : r_value + 4'd1;
        end
    end

    assign value  = r_value;
    assign at_max = w_at_max;

endmodule

// File: rtl/lap_stopwatch.sv
// Lap stopwatch: synchronised buttons, run FSM, prescaled BCD chain, lap hold and
// a registered multiplexed 7-segment driver.
module lap_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int unsigned       CLK_HZ   = 100000000,
    parameter int unsigned       TICK_HZ  = 10,
    parameter int unsigned       SCAN_HZ  = 1000,
    parameter int unsigned       DIGITS   = 4,
    parameter logic [DIGITS-1:0] DOT_MASK = DIGITS'(4'b0110)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pp,
    input  logic              lap,
    input  logic              clr,
    output logic [6:0]        disp,
    output logic [DIGITS-1:0] mux,
    output logic              dots,
    output logic              running,
    output logic              overflow
);

    localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int unsigned TICK_W   = $clog2(TICK_DIV);
    localparam int unsigned SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W    = $clog2(DIGITS);

    // ---------------- button synchronisers + edge detect ----------------
    // Bit 0 = pp, bit 1 = lap, bit 2 = clr. Flops clear on reset, so a button
    // already held at release is seen as a fresh press.
    logic [2:0] w_btn;
    logic [2:0] r_sync1, r_sync2, r_sync3;
    logic [2:0] w_pulse;
    logic       w_pp_p, w_lap_p, w_clr_p;

    assign w_btn = {clr, lap, pp};

    // Two-flop synchroniser plus one history flop for rising-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_pulse = r_sync2 & ~r_sync3;
    assign w_pp_p  = w_pulse[0];
    assign w_lap_p = w_pulse[1];
    assign w_clr_p = w_pulse[2];

    // ---------------- run state ----------------
    run_state_e r_state;
    logic       w_run;
    logic       w_clr_act;

    // Run FSM: each pp pulse toggles between stopped and running.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StStopped;
        end else if (w_pp_p) begin
            r_state <= (r_state == StStopped) ? StRunning : StStopped;
        end
    end

    assign w_run     = (r_state == StRunning);
    // clr is judged against the state before any same-cycle pp toggle.
    assign w_clr_act = w_clr_p & ~w_run;

    // ---------------- prescaler ----------------
    logic [TICK_W-1:0] r_presc;
    logic              w_tick;

    assign w_tick = w_run && (r_presc == TICK_W'(TICK_DIV - 1));

    // Tick prescaler: parked at 0 while stopped so the first tick is a full period out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc <= '0;
        end else if (!w_run || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // ---------------- digit chain ----------------
    logic [3:0]        w_value [DIGITS];
    logic [DIGITS-1:0] w_at_max;
    logic [DIGITS-1:0] w_inc;
    logic              w_wrap;

    assign w_inc[0] = w_tick;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        if (gi > 0) begin : g_carry
            assign w_inc[gi] = w_inc[gi-1] & w_at_max[gi-1];
        end
        bcd_digit #(
            .MODULUS(digit_modulus(gi))
        ) u_digit (
            .clk   (clk),
            .reset (reset),
            .clr   (w_clr_act),
            .inc   (w_inc[gi]),
            .value (w_value[gi]),
            .at_max(w_at_max[gi])
        );
    end

    assign w_wrap = w_tick & (&w_at_max);

    logic r_ovf;

    // Sticky overflow: set on full-count wrap, cleared only by an accepted clr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else if (w_clr_act) begin
            r_ovf <= 1'b0;
        end else if (w_wrap) begin
            r_ovf <= 1'b1;
        end
    end

    // ---------------- lap hold ----------------
    logic       r_hold_on;
    logic [3:0] r_hold [DIGITS];

    // Lap toggles hold while running; entering hold snapshots the live count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold_on <= 1'b0;
            for (int i = 0; i < DIGITS; i++) r_hold[i] <= '0;
        end else if (w_clr_act) begin
            r_hold_on <= 1'b0;
            for (int i = 0; i < DIGITS; i++) r_hold[i] <= '0;
        end else if (w_lap_p && w_run) begin
            r_hold_on <= ~r_hold_on;
            if (!r_hold_on) r_hold <= w_value;
        end
    end

    // ---------------- display scan ----------------
    logic [SCAN_W-1:0] r_scan_cnt;
    logic [IDX_W-1:0]  r_idx;

    // Scan counter: step the digit index once per scan period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
        end else if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            r_scan_cnt <= '0;
            r_idx      <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    logic [3:0]        w_shown;
    logic [6:0]        r_disp;
    logic [DIGITS-1:0] r_mux;
    logic              r_dots;

    assign w_shown = r_hold_on ? r_hold[r_idx] : w_value[r_idx];

    // Output registers: segments, digit enable and dot all update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_disp <= seg_code(4'd0);
            r_mux  <= ~DIGITS'(1);
            r_dots <= ~DOT_MASK[0];
        end else begin
            r_disp <= seg_code(w_shown);
            r_mux  <= ~(DIGITS'(1) << r_idx);
            r_dots <= ~DOT_MASK[r_idx];
        end
    end

    assign disp     = r_disp;
    assign mux      = r_mux;
    assign dots     = r_dots;
    assign running  = w_run;
    assign overflow = r_ovf;

endmodule
